// File: rtl/seq_detector_param_if.sv
// Serial pattern detector bus: sample stream, pattern load/clear controls and match status.
// Latency: n/a (signal bundle only).
// Backpressure: none; the detector accepts a sample on every cycle Valid is high.
interface seq_detector_param_if #(
   parameter int PATTERN_LEN = 4,
   parameter int COUNT_W     = 8
);
   logic                   X;
   logic                   Valid;
   logic                   Load;
   logic [PATTERN_LEN-1:0] Pattern;
   logic                   Clear;
   logic                   Y;
   logic [COUNT_W-1:0]     Count;
   logic                   Armed;

   // Stimulus side: drives the sample stream and controls, observes results.
   modport master (
      output X, Valid, Load, Pattern, Clear,
      input  Y, Count, Armed
   );

   // Detector side.
   modport slave (
      input  X, Valid, Load, Pattern, Clear,
      output Y, Count, Armed
   );
endinterface

// File: rtl/seq_detector_param.sv
// Serial bit-pattern detector with loadable pattern, overlap mode and saturating match counter.
// Latency: Y pulses 1 cycle after the matching sample's edge; Armed is decoded from state only.
// Backpressure: none; Valid=0 simply freezes the history so gaps never break a sequence.
module seq_detector_param #(
   parameter int                     PATTERN_LEN     = 4,
   parameter logic [PATTERN_LEN-1:0] DEFAULT_PATTERN = 4'b1011,
   parameter int                     OVERLAP         = 1,
   parameter int                     COUNT_W         = 8
) (
   input logic                 Clock,
   input logic                 Reset,
   seq_detector_param_if.slave io
);
   localparam int            FW        = $clog2(PATTERN_LEN + 1);
   localparam logic [FW-1:0] FILL_FULL = FW'(PATTERN_LEN);
   localparam logic [FW-1:0] FILL_LAST = FW'(PATTERN_LEN - 1);

   localparam logic [1:0] EMPTY   = 2'd0;
   localparam logic [1:0] FILLING = 2'd1;
   localparam logic [1:0] ARMED   = 2'd2;

   logic [PATTERN_LEN-1:0] pat;
   logic [PATTERN_LEN-1:0] hist;
   logic [PATTERN_LEN-1:0] window;
   logic [FW-1:0]          fill;
   logic [FW-1:0]          fill_inc;
   logic [1:0]             state;
   logic                   sample;
   logic                   match;
   logic                   y_q;
   logic [COUNT_W-1:0]     count_q;

   // Window as it would look after this sample; a match needs the window completed by this bit.
   always_comb begin
      window   = {hist[PATTERN_LEN-2:0], io.X};
      sample   = io.Valid & ~io.Load;
      match    = sample && (window == pat) && ((state == ARMED) || (fill == FILL_LAST));
      fill_inc = (fill == FILL_FULL) ? FILL_FULL : fill + FW'(1);
   end

   // Pattern, history, fill level and state; Load wins over a same-cycle sample.
   always_ff @(posedge Clock) begin
      if (!Reset) begin
         pat   <= DEFAULT_PATTERN;
         hist  <= '0;
         fill  <= '0;
         state <= EMPTY;
      end else if (io.Load) begin
         pat   <= io.Pattern;
         fill  <= '0;
         state <= EMPTY;
      end else if (io.Valid) begin
         hist <= window;
         if (match && (OVERLAP == 0)) begin
            fill  <= '0;
            state <= EMPTY;
         end else begin
            fill  <= fill_inc;
            state <= (fill_inc == FILL_FULL) ? ARMED : FILLING;
         end
      end
   end

   // Registered match pulse and saturating match counter; a same-cycle match survives Clear.
   always_ff @(posedge Clock) begin
      if (!Reset) begin
         y_q     <= 1'b0;
         count_q <= '0;
      end else begin
         y_q <= match;
         if (io.Clear)
            count_q <= match ? COUNT_W'(1) : '0;
         else if (match && (count_q != '1))
            count_q <= count_q + COUNT_W'(1);
      end
   end

   assign io.Y     = y_q;
   assign io.Count = count_q;
   assign io.Armed = (state == ARMED);

endmodule

// File: tb/tb_seq_detector_param.sv
// Randomized + directed bench for seq_detector_param across overlap, non-overlap and narrow-counter builds.
// Latency: every output is compared 1 ns after each rising edge against a sample-list reference.
// Backpressure: n/a; the stimulus drives Valid directly.
module tb_seq_detector_param;
   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       x = 1'b0, valid = 1'b0, load = 1'b0, clear = 1'b0;
   logic [3:0] pattern = 4'b0000;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clock = ~clock;

   seq_detector_param_if #(.PATTERN_LEN(4), .COUNT_W(8)) if_ov ();
   seq_detector_param_if #(.PATTERN_LEN(4), .COUNT_W(8)) if_nov ();
   seq_detector_param_if #(.PATTERN_LEN(4), .COUNT_W(2)) if_sat ();

   assign if_ov.X  = x;  assign if_ov.Valid  = valid; assign if_ov.Load  = load;
   assign if_ov.Pattern  = pattern; assign if_ov.Clear  = clear;
   assign if_nov.X = x;  assign if_nov.Valid = valid; assign if_nov.Load = load;
   assign if_nov.Pattern = pattern; assign if_nov.Clear = clear;
   assign if_sat.X = x;  assign if_sat.Valid = valid; assign if_sat.Load = load;
   assign if_sat.Pattern = pattern; assign if_sat.Clear = clear;

   seq_detector_param #(.PATTERN_LEN(4), .DEFAULT_PATTERN(4'b1011), .OVERLAP(1), .COUNT_W(8))
      dut_ov (.Clock(clock), .Reset(reset), .io(if_ov));
   seq_detector_param #(.PATTERN_LEN(4), .DEFAULT_PATTERN(4'b1011), .OVERLAP(0), .COUNT_W(8))
      dut_nov (.Clock(clock), .Reset(reset), .io(if_nov));
   seq_detector_param #(.PATTERN_LEN(4), .DEFAULT_PATTERN(4'b1011), .OVERLAP(1), .COUNT_W(2))
      dut_sat (.Clock(clock), .Reset(reset), .io(if_sat));

   // Reference: list of valid samples since the last reset/load; a match is "last 4 samples,
   // oldest first, equal the pattern". Non-overlap additionally needs 4 samples after the
   // previous non-overlap match (tracked as an index into the list).
   bit         hq[$];
   int         start_nov = 0;
   logic [3:0] m_pat = 4'b1011;
   logic       exp_y[3];
   int         exp_cnt[3];
   logic       exp_arm[3];
   int         cnt_max[3] = '{255, 255, 3};

   function automatic logic [3:0] tail4();
      logic [3:0] v = 4'b0000;
      for (int i = 0; i < 4; i++) v = {v[2:0], logic'(hq[hq.size() - 4 + i])};
      return v;
   endfunction

   task automatic chk_val(input string tag, input int got, input int exp);
      n_checks++;
      if (got == exp) n_pass++;
      else $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
   endtask

   task automatic model(input logic r, xx, vv, ll, input logic [3:0] pp, input logic cc);
      logic mo = 1'b0, mn = 1'b0;
      if (!r) begin
         hq.delete(); start_nov = 0; m_pat = 4'b1011;
         for (int k = 0; k < 3; k++) begin exp_y[k] = 1'b0; exp_cnt[k] = 0; end
      end else begin
         if (ll) begin
            m_pat = pp; hq.delete(); start_nov = 0;
         end else if (vv) begin
            hq.push_back(bit'(xx));
            if (hq.size() >= 4 && tail4() == m_pat) begin
               mo = 1'b1;
               if (hq.size() - start_nov >= 4) begin mn = 1'b1; start_nov = hq.size(); end
            end
         end
         exp_y[0] = mo; exp_y[1] = mn; exp_y[2] = mo;
         for (int k = 0; k < 3; k++) begin
            if (cc) exp_cnt[k] = exp_y[k] ? 1 : 0;
            else if (exp_y[k] && exp_cnt[k] < cnt_max[k]) exp_cnt[k]++;
         end
      end
      exp_arm[0] = (hq.size() >= 4);
      exp_arm[1] = (hq.size() - start_nov >= 4);
      exp_arm[2] = exp_arm[0];
   endtask

   task automatic step(input logic r, xx, vv, ll, input logic [3:0] pp, input logic cc);
      reset = r; x = xx; valid = vv; load = ll; pattern = pp; clear = cc;
      model(r, xx, vv, ll, pp, cc);
      @(posedge clock);
      #1;
      chk_val("ov_y",    int'(if_ov.Y),     int'(exp_y[0]));
      chk_val("ov_cnt",  int'(if_ov.Count), exp_cnt[0]);
      chk_val("ov_arm",  int'(if_ov.Armed), int'(exp_arm[0]));
      chk_val("nov_y",   int'(if_nov.Y),    int'(exp_y[1]));
      chk_val("nov_cnt", int'(if_nov.Count), exp_cnt[1]);
      chk_val("nov_arm", int'(if_nov.Armed), int'(exp_arm[1]));
      chk_val("sat_y",   int'(if_sat.Y),    int'(exp_y[2]));
      chk_val("sat_cnt", int'(if_sat.Count), exp_cnt[2]);
      chk_val("sat_arm", int'(if_sat.Armed), int'(exp_arm[2]));
   endtask

   task automatic bits(input logic [15:0] seq, input int n);
      for (int i = n - 1; i >= 0; i--) step(1'b1, seq[i], 1'b1, 1'b0, 4'b0000, 1'b0);
   endtask

   task automatic do_reset();
      step(1'b0, 1'b0, 1'b1, 1'b1, 4'b1111, 1'b1);
      step(1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0);
   endtask

   initial begin
      @(posedge clock);
      #1;
      do_reset();
      // Basic match, then overlapping continuation 1,0,1,1,0,1,1.
      bits(16'b1011, 4);
      bits(16'b011, 3);
      // Gap in Valid between 1,0 and 1,1.
      do_reset();
      bits(16'b10, 2);
      for (int i = 0; i < 5; i++) step(1'b1, 1'(i & 1), 1'b0, 1'b0, 4'b0000, 1'b0);
      bits(16'b11, 2);
      // Load together with Valid discards the sample; then 0,1,1,0.
      step(1'b1, 1'b0, 1'b1, 1'b1, 4'b0110, 1'b0);
      bits(16'b0110, 4);
      // Clear in the same cycle as a match.
      step(1'b1, 1'b0, 1'b0, 1'b1, 4'b1011, 1'b0);
      bits(16'b101, 3);
      step(1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b1);
      // Reset after 3 bits of a match, then a fresh 1,0,1,1.
      bits(16'b101, 3);
      step(1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0);
      bits(16'b1011, 4);
      // Repeated matches drive the narrow counter into saturation.
      for (int i = 0; i < 5; i++) bits(16'b1011, 4);
      // Randomized traffic with occasional load, clear and reset.
      for (int i = 0; i < 1500; i++)
         step($urandom_range(0, 99) != 0, 1'($urandom_range(0, 1)), $urandom_range(0, 9) < 7,
              $urandom_range(0, 49) == 0, 4'($urandom_range(0, 15)), $urandom_range(0, 39) == 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/seq_detector_param.md
SEQ_DETECTOR_PARAM -- requirements
Module: seq_detector_param

Interface
REQ-001 Parameter PATTERN_LEN, default 4, SHALL set the pattern/window length in bits (legal 2..16).
REQ-002 Parameter DEFAULT_PATTERN, default 4'b1011, SHALL set the pattern value loaded at reset.
REQ-003 Parameter OVERLAP, default 1, SHALL select overlapping (1) or non-overlapping (0) matching.
REQ-004 Parameter COUNT_W, default 8, SHALL set the width of the match counter.
REQ-005 Port list, one per line:
  Clock    in   1            single clock, all state updates on posedge
  Reset    in   1            synchronous, active-low reset
  X        in   1            serial data bit
  Valid    in   1            X is sampled only when Valid=1
  Load     in   1            latch Pattern into the pattern register
  Pattern  in   PATTERN_LEN  new pattern value; MSB is the first bit expected
  Clear    in   1            zero the match counter
  Y        out  1            registered match pulse
  Count    out  COUNT_W      saturating number of matches
  Armed    out  1            window is full, so a match is possible on the next sample

Function
REQ-006 The block SHALL hold the pattern register pat, history shift register hist[PATTERN_LEN-1:0], fill counter fill, and FSM state.
REQ-007 FSM states SHALL be EMPTY (fill=0), FILLING (0<fill<PATTERN_LEN) and ARMED (fill=PATTERN_LEN).
REQ-008 On Valid=1 (Load=0), hist SHALL shift left with X entering bit 0.
REQ-008a On Valid=1 (Load=0), fill SHALL increment, saturating at PATTERN_LEN.
REQ-009 Transitions: EMPTY->FILLING on valid sample; FILLING->ARMED when fill reaches PATTERN_LEN; ARMED stays ARMED on valid sample with no match.
REQ-010 A match SHALL be a valid sample where {hist[PATTERN_LEN-2:0],X}==pat and either the state is ARMED or fill=PATTERN_LEN-1.
REQ-011 Y SHALL be 1 for exactly one cycle, the cycle after the matching sample's clock edge (latency 1), and 0 otherwise.
REQ-012 With OVERLAP=1, a match SHALL leave fill at PATTERN_LEN (state ARMED), so overlapping occurrences are each reported.
REQ-013 With OVERLAP=0, a match SHALL set fill=0 and state EMPTY, so the next match needs PATTERN_LEN fresh samples.
REQ-014 Valid=0 SHALL freeze hist, fill and state; gaps in Valid SHALL not break a sequence.
REQ-015 Load=1 SHALL set pat=Pattern, fill=0 and state EMPTY, and SHALL not alter hist or Count.
REQ-016 When Load=1 and Valid=1 together, Load SHALL win and the sample SHALL be discarded (no shift, no match).
REQ-017 Count SHALL increment by 1 on each match and saturate at 2^COUNT_W-1.
REQ-018 Clear=1 SHALL set Count=0; if a match occurs in the same cycle, Count SHALL become 1.
REQ-019 Armed SHALL equal (state==ARMED) and is combinational from state only.
REQ-020 No output SHALL depend combinationally on X, Valid, Load or Clear.

Reset
REQ-021 When Reset=0 at a rising Clock edge: pat=DEFAULT_PATTERN, hist=0, fill=0, state=EMPTY, Y=0, Count=0, Armed=0.
REQ-022 Reset SHALL override Load, Valid and Clear in the same cycle.
REQ-023 Reset asserted mid-sequence SHALL discard partial progress; the first match after release requires PATTERN_LEN new valid samples.

Verification (PATTERN_LEN=4, COUNT_W=8 unless stated)
REQ-024 Reset, then stream X=1,0,1,1 with Valid=1 -> Y=1 one cycle after the 4th bit; Count=1; Armed=1 from the 4th edge.
REQ-025 OVERLAP=1, stream 1,0,1,1,0,1,1 -> Y pulses after bits 4 and 7; Count=2.
REQ-025a OVERLAP=0, same stream -> Y pulses after bit 4 only; Count=1.
REQ-026 Stream 1,0 then Valid=0 for 5 cycles, then 1,1 -> single Y pulse after the final bit; no pulse during the gap.
REQ-027 Load with Pattern=4'b0110 and Valid=1 in the same cycle -> sample ignored, Armed=0; then stream 0,1,1,0 -> Y pulse; Count increments.
REQ-028 COUNT_W=2, four matches -> Count=3 (saturated).
REQ-028a Clear in the same cycle as a match -> Count=1.
REQ-028b Reset=0 after 3 bits of a match -> all outputs 0; a following 1,0,1,1 matches only after all 4 bits.
